// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the colour logic.
// frameCount exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
  logic       screenEnd;
  logic       active;
  logic       hSync;
  logic       vSync;
  logic [9:0] x;
  logic [8:0] y;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frameCount;

  modport master (
    output screenEnd, active, hSync, vSync,
    output x, y, frameCount
  );
  modport slave (
    input screenEnd, active, hSync, vSync,
    input x, y, frameCount
  );
`else
  modport master (
    output screenEnd, active, hSync, vSync,
    output x, y
  );
  modport slave (
    input screenEnd, active, hSync, vSync,
    input x, y
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running 640x480@60 raster timing generator (25 MHz pixel clock).
// Optional 16-bit frame counter enabled by VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic clk25,
  input  logic reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL =
    WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST =
    11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST =
    10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(WIDTH);
  localparam logic [9:0]  V_VIS  = 10'(HEIGHT);
  localparam logic [10:0] HS_BEG =
    11'(WIDTH + H_FRONT);
  localparam logic [10:0] HS_END =
    11'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_BEG =
    10'(HEIGHT + V_FRONT);
  localparam logic [9:0]  VS_END =
    10'(HEIGHT + V_FRONT + V_SYNC);

  logic [10:0] hCount;
  logic [9:0]  vCount;
  logic        h_last;
  logic        v_last;
  logic        h_vis;
  logic        v_vis;

  assign h_last = (hCount == H_LAST);
  assign v_last = (vCount == V_LAST);
  assign h_vis  = (hCount < H_VIS);
  assign v_vis  = (vCount < V_VIS);

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (h_last) begin
      hCount <= '0;
      vCount <= v_last ? '0 : vCount + 10'd1;
    end else begin
      hCount <= hCount + 11'd1;
    end
  end

  // Outputs decode the counters directly, no pipeline delay.
  assign vga.active = h_vis & v_vis;
  assign vga.x      = h_vis ? hCount[9:0] : '0;
  assign vga.y      = v_vis ? vCount[8:0] : '0;
  assign vga.hSync  =
    ~((hCount >= HS_BEG) & (hCount < HS_END));
  assign vga.vSync  =
    ~((vCount >= VS_BEG) & (vCount < VS_END));
  assign vga.screenEnd =
    (hCount == H_VIS) & (vCount == V_VIS);

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_q;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset)
      frame_q <= '0;
    else if (h_last & v_last)
      frame_q <= frame_q + 16'd1;
  end

  assign vga.frameCount = frame_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized self-checking bench for vga_timing_gen, using a reduced
// raster so several frames fit in a short run.
module tb_vga_timing_gen;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 6;
  localparam int VF = 3;
  localparam int VS = 2;
  localparam int VB = 5;
  localparam int HT = W + HF + HS + HB;
  localparam int VT = H + VF + VS + VB;
  localparam int FR = HT * VT;

  logic clk25 = 1'b0;
  logic reset = 1'b0;

  vga_timing_gen_if vga ();

  vga_timing_gen #(
    .WIDTH  (W),
    .HEIGHT (H),
    .H_FRONT(HF),
    .H_SYNC (HS),
    .H_BACK (HB),
    .V_FRONT(VF),
    .V_SYNC (VS),
    .V_BACK (VB)
  ) dut (
    .clk25(clk25),
    .reset(reset),
    .vga  (vga)
  );

  always #5 clk25 = ~clk25;

  // Reference: pixel clocks elapsed since reset released.
  longint t = 0;
  always @(posedge clk25 or posedge reset)
    if (reset) t <= 0;
    else       t <= t + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %0d exp %0d",
               tag, t, got, exp);
    end
  endtask

  task automatic check_out();
    longint h, v;
    h = t % HT;
    v = (t / HT) % VT;
    chk("active", vga.active, (h < W) && (v < H));
    chk("x", vga.x, (h < W) ? h : 0);
    chk("y", vga.y, (v < H) ? v : 0);
    chk("hsync", vga.hSync,
        !((h >= W + HF) && (h < W + HF + HS)));
    chk("vsync", vga.vSync,
        !((v >= H + VF) && (v < H + VF + VS)));
    chk("screen_end", vga.screenEnd,
        (h == W) && (v == H));
`ifdef VGA_FRAME_COUNT_EN
    chk("frame_count", vga.frameCount,
        (t / FR) % 65536);
`endif
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk25);
      check_out();
    end
  endtask

  // Assert reset mid-cycle, check at once, release on a negedge.
  task automatic pulse_reset(input int dly,
                             input int hold);
    #(dly) reset = 1'b1;
    #1;
    chk("rst_x", vga.x, 0);
    chk("rst_y", vga.y, 0);
    chk("rst_active", vga.active, 1);
    chk("rst_hsync", vga.hSync, 1);
    chk("rst_vsync", vga.vSync, 1);
    chk("rst_se", vga.screenEnd, 0);
    repeat (hold) begin
      @(negedge clk25);
      check_out();
    end
    reset = 1'b0;
  endtask

  longint pulses[$];
  int act_n, hs_n, vs_n;
  longint hs_first, vs_first;

  initial begin
    #1 reset = 1'b1;
    #1 check_out();
    repeat (3) begin
      @(negedge clk25);
      check_out();
    end
    reset = 1'b0;

    act_n = 0; hs_n = 0; vs_n = 0;
    hs_first = -1; vs_first = -1;
    for (int i = 0; i < 3 * FR; i++) begin
      check_out();
      if (vga.screenEnd) pulses.push_back(t);
      if (t < HT) begin
        if (vga.active) act_n++;
        if (!vga.hSync) begin
          if (hs_n == 0) hs_first = t;
          hs_n++;
        end
      end
      if (t < FR && !vga.vSync) begin
        if (vs_n == 0) vs_first = t;
        vs_n++;
      end
      @(negedge clk25);
    end
    chk("line_active", act_n, W);
    chk("hsync_len", hs_n, HS);
    chk("hsync_start", hs_first, W + HF);
    chk("vsync_len", vs_n, VS * HT);
    chk("vsync_start", vs_first, (H + VF) * HT);
    chk("se_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      chk("se_first", pulses[0], H * HT + W);
      for (int i = 1; i < 3; i++)
        chk("se_period", pulses[i] - pulses[i-1], FR);
    end

    // Mid-line reset near column 30.
    while (t % HT != 30) run(1);
    pulse_reset(2, 2);
    @(negedge clk25);
    chk("x_after_rel", vga.x, 1);
    check_out();

    for (int s = 0; s < 14; s++) begin
      run($urandom_range(1, 2500));
      if ($urandom_range(0, 2) != 0) begin
        @(posedge clk25);
        pulse_reset($urandom_range(1, 3),
                    $urandom_range(1, 3));
      end
    end
    run(FR + 5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running raster timing generator for a 640x480@60 Hz VGA display, driven by a 25 MHz pixel clock.
- Produces horizontal/vertical sync, an active-video flag, the current pixel coordinate, and a one-cycle frame-boundary strobe.
- Sits between the pixel-clock PLL and the colour-selection logic. Downstream logic masks its colour with `active` and latches per-frame sprite positions on `screenEnd`.

Parameters:
- WIDTH, 640: active pixels per line.
- HEIGHT, 480: active lines per frame.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.

Ports:
- clk25  input  1  pixel clock, 25 MHz; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- screenEnd  output  1  one-cycle pulse at the frame boundary.
- active  output  1  high while the current pixel is inside the visible area.
- hSync  output  1  horizontal sync, active low.
- vSync  output  1  vertical sync, active low.
- x  output  10  pixel column, counted from the left.
- y  output  9  pixel row, counted from the top.

Behaviour:
- Derived totals:
  - H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK (800 by default).
  - V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK (525 by default).
- Internal registers:
  - hCount, 11 bits: 0..H_TOTAL-1.
  - vCount, 10 bits: 0..V_TOTAL-1.
- Counter update, every clk25 rising edge:
  - hCount increments.
  - At hCount==H_TOTAL-1, hCount wraps to 0 and vCount increments.
  - When hCount==H_TOTAL-1 and vCount==V_TOTAL-1, both counters wrap to 0 (new frame).
- Reset:
  - reset high asynchronously forces hCount=0 and vCount=0.
  - The counters hold 0 while reset is high.
  - Counting resumes on the first clk25 rising edge after reset deasserts.
  - Reset mid-line or mid-frame restarts at pixel (0,0) with no partial-frame strobe.
- Outputs are combinational decodes of the counters (zero latency relative to the counters):
  - active = (hCount < WIDTH) && (vCount < HEIGHT).
  - x = hCount[9:0] when hCount < WIDTH, else 0.
  - y = vCount[8:0] when vCount < HEIGHT, else 0.
  - hSync = 0 when WIDTH+H_FRONT <= hCount < WIDTH+H_FRONT+H_SYNC (656..751 by default), else 1.
  - vSync = 0 when HEIGHT+V_FRONT <= vCount < HEIGHT+V_FRONT+V_SYNC (490..491 by default), else 1.
  - screenEnd = 1 only when hCount==WIDTH and vCount==HEIGHT. This is the first blanking pixel after the last visible pixel of the frame: exactly one clk25 cycle per frame.
- Values during and immediately after reset:
  - active=1, x=0, y=0, hSync=1, vSync=1, screenEnd=0.
- Period: one frame = H_TOTAL*V_TOTAL = 420000 clk25 cycles by default.
- Parameter constraints (need not be checked in RTL):
  - WIDTH <= 1023.
  - HEIGHT <= 511.
  - H_TOTAL <= 2047.
  - V_TOTAL <= 1023.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- When defined:
  - Adds output port frameCount, 16 bits.
  - frameCount is 0 on reset.
  - It increments by 1 on the clk25 edge where both counters wrap to 0.
  - It wraps from 65535 to 0.
- When undefined:
  - The port and its register do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset: assert reset asynchronously mid-line at hCount≈300 -> immediately x=0, y=0, active=1, hSync=1, vSync=1, screenEnd=0. After release, x=1 on the next edge.
- Horizontal timing: run one line -> active high for exactly 640 cycles. hSync low for exactly 96 cycles, starting at cycle 656. Line period 800 cycles; x returns to 0 at the wrap.
- Vertical timing: run one full frame -> vSync low for exactly 2 lines (1600 cycles), starting at line 490. y counts 0..479, then reads 0 during blanking. Frame period 420000 cycles.
- screenEnd: over 3 frames -> exactly 3 single-cycle pulses spaced 420000 cycles apart. Each pulse coincides with hCount=640, vCount=480, where active=0.
- Wrap: at hCount=799, vCount=524 -> next edge gives x=0, y=0, active=1.
- VGA_FRAME_COUNT_EN: with the macro defined, run 2 frames from reset -> frameCount goes 0→1→2. With the macro undefined, the build has no frameCount port.
